// File: rtl/altmem_arbiter.sv
// altmem_arbiter: two-client arbiter/sequencer in front of one simple
// dual-port BRAM (one write port, one read port, read data one cycle after
// the read enable). Each cycle issues at most one write and one read, with
// independent round-robin priority for each port.
//
// Optional feature: define ALTMEM_ARB_FWD_EN to forward write data to a
// same-address read granted in the same cycle. Without it, such a read is
// held off for one cycle and then reads the committed data from the RAM.
//
// Handshake: a request transfers when cN_valid && cN_ready. cN_ready is a
// combinational function of the valid/write/addr inputs and the priority
// flops; a client keeps its request stable while cN_valid && !cN_ready.
// Responses (cN_rsp_valid) have no backpressure and arrive exactly one
// cycle after the read was accepted.
module altmem_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  // client 0
  input  logic                  c0_valid,
  output logic                  c0_ready,
  input  logic                  c0_write,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [DATA_WIDTH-1:0] c0_wdata,
  output logic                  c0_rsp_valid,
  output logic [DATA_WIDTH-1:0] c0_rsp_data,
  // client 1
  input  logic                  c1_valid,
  output logic                  c1_ready,
  input  logic                  c1_write,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [DATA_WIDTH-1:0] c1_wdata,
  output logic                  c1_rsp_valid,
  output logic [DATA_WIDTH-1:0] c1_rsp_data,
  // RAM
  output logic [ADDR_WIDTH-1:0] mem_addrw,
  output logic [DATA_WIDTH-1:0] mem_di,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addrr,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_do
);

  // Request decode: which client wants which port (nothing while in reset).
  logic wr_req0, wr_req1;
  logic rd_req0, rd_req1;

  // Port grants after arbitration.
  logic wr_gnt0, wr_gnt1;
  logic rd_pick0, rd_pick1;   // read winner before collision handling
  logic rd_gnt0, rd_gnt1;     // read grant actually issued
  logic wr_any, rd_any;
  logic collide;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // Registered state: priorities (0 = client 0 first) and pending read.
  logic wr_prio_q, wr_prio_d;
  logic rd_prio_q, rd_prio_d;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;

`ifdef ALTMEM_ARB_FWD_EN
  logic                  fwd_hit_q, fwd_hit_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
`endif

  logic [DATA_WIDTH-1:0] rsp_data;

  // Decode requests per port; reset masks every request.
  always_comb begin
    wr_req0 = 1'b0;
    wr_req1 = 1'b0;
    rd_req0 = 1'b0;
    rd_req1 = 1'b0;
    if (!RST) begin
      wr_req0 = c0_valid &  c0_write;
      wr_req1 = c1_valid &  c1_write;
      rd_req0 = c0_valid & ~c0_write;
      rd_req1 = c1_valid & ~c1_write;
    end
  end

  // Round-robin arbitration per port, then same-address collision handling.
  always_comb begin
    // write port: a lone candidate wins, a tie goes to wr_prio_q
    wr_gnt0 = wr_req0 & (~wr_req1 | ~wr_prio_q);
    wr_gnt1 = wr_req1 & (~wr_req0 |  wr_prio_q);
    wr_any  = wr_gnt0 | wr_gnt1;

    // read port: same rule with rd_prio_q
    rd_pick0 = rd_req0 & (~rd_req1 | ~rd_prio_q);
    rd_pick1 = rd_req1 & (~rd_req0 |  rd_prio_q);

    // unused RAM inputs default to client 0 to keep the muxes small
    wr_addr = wr_gnt1  ? c1_addr  : c0_addr;
    wr_data = wr_gnt1  ? c1_wdata : c0_wdata;
    rd_addr = rd_pick1 ? c1_addr  : c0_addr;

    // RAM output is undefined when both ports hit the same word together
    collide = wr_any & (rd_pick0 | rd_pick1) & (rd_addr == wr_addr);

`ifdef ALTMEM_ARB_FWD_EN
    // forwarding covers the collision, so the read always goes ahead
    rd_gnt0 = rd_pick0;
    rd_gnt1 = rd_pick1;
`else
    // hold the read one cycle so it sees the committed write
    rd_gnt0 = rd_pick0 & ~collide;
    rd_gnt1 = rd_pick1 & ~collide;
`endif
    rd_any = rd_gnt0 | rd_gnt1;
  end

  // Next-state for priorities, pending read and forward register.
  always_comb begin
    wr_prio_d  = wr_prio_q;
    rd_prio_d  = rd_prio_q;
    rd_pend_d  = rd_any;
    rd_owner_d = rd_gnt1;

    // contested grant: priority moves to the loser
    if (wr_req0 && wr_req1) begin
      wr_prio_d = wr_gnt0;
    end
    // a suppressed read leaves rd_prio untouched
    if (rd_req0 && rd_req1 && rd_any) begin
      rd_prio_d = rd_gnt0;
    end

`ifdef ALTMEM_ARB_FWD_EN
    fwd_hit_d  = collide & rd_any;
    fwd_data_d = fwd_data_q;
    if (collide && rd_any) begin
      fwd_data_d = wr_data;
    end
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_prio_q  <= 1'b0;
      rd_prio_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
`ifdef ALTMEM_ARB_FWD_EN
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
`endif
    end else begin
      wr_prio_q  <= wr_prio_d;
      rd_prio_q  <= rd_prio_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
`ifdef ALTMEM_ARB_FWD_EN
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
`endif
    end
  end

  // Client handshakes and RAM port drive.
  always_comb begin
    c0_ready  = wr_gnt0 | rd_gnt0;
    c1_ready  = wr_gnt1 | rd_gnt1;
    mem_wen   = wr_any;
    mem_addrw = wr_addr;
    mem_di    = wr_data;
    mem_ren   = rd_any;
    mem_addrr = rd_addr;
  end

  // Read response: only the owner of the pending read sees rsp_valid.
  always_comb begin
`ifdef ALTMEM_ARB_FWD_EN
    rsp_data = fwd_hit_q ? fwd_data_q : mem_do;
`else
    rsp_data = mem_do;
`endif
    c0_rsp_valid = rd_pend_q & ~rd_owner_q & ~RST;
    c1_rsp_valid = rd_pend_q &  rd_owner_q & ~RST;
    c0_rsp_data  = rsp_data;
    c1_rsp_data  = rsp_data;
  end

endmodule

// File: tb/tb_altmem_arbiter.sv
// tb_altmem_arbiter: scoreboard bench for altmem_arbiter. A behavioural RAM
// answers the RAM port (garbage on same-address collisions), a reference
// model predicts grants and read data from the arbitration rules, and
// per-client monitors pop expected responses as the DUT presents them.
module tb_altmem_arbiter;
  localparam int AW = 9;
  localparam int DW = 64;

  // clock / reset
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic          c0_valid = 0, c0_write = 0, c1_valid = 0, c1_write = 0;
  logic [AW-1:0] c0_addr = '0, c1_addr = '0;
  logic [DW-1:0] c0_wdata = '0, c1_wdata = '0;
  logic          c0_ready, c1_ready, c0_rsp_valid, c1_rsp_valid;
  logic [DW-1:0] c0_rsp_data, c1_rsp_data;
  logic [AW-1:0] mem_addrw, mem_addrr;
  logic [DW-1:0] mem_di;
  logic [DW-1:0] mem_do = '0;
  logic          mem_wen, mem_ren;

  altmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST),
    .c0_valid(c0_valid), .c0_ready(c0_ready), .c0_write(c0_write),
    .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_data(c0_rsp_data),
    .c1_valid(c1_valid), .c1_ready(c1_ready), .c1_write(c1_write),
    .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_rsp_valid(c1_rsp_valid), .c1_rsp_data(c1_rsp_data),
    .mem_addrw(mem_addrw), .mem_di(mem_di), .mem_wen(mem_wen),
    .mem_addrr(mem_addrr), .mem_ren(mem_ren), .mem_do(mem_do)
  );

  // behavioural BRAM: registered read, undefined data on collision
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (mem_ren) begin
      if (mem_wen && mem_addrw == mem_addrr) mem_do <= {$urandom, $urandom};
      else mem_do <= ram[mem_addrr];
    end
    if (mem_wen) ram[mem_addrw] <= mem_di;
  end

  // scoreboard state
  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q0[$], exp_q1[$];
  int            due_q0[$], due_q1[$];
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  bit  m_wr_prio = 0, m_rd_prio = 0;
  bit  done = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: grants from the round-robin rules, data from model_mem
  always @(negedge CLK) begin
    bit wq0, wq1, rq0, rq1, gw0, gw1, gr0, gr1;
    logic [AW-1:0] ra, wa;
    wq0 = c0_valid &&  c0_write;  wq1 = c1_valid &&  c1_write;
    rq0 = c0_valid && !c0_write;  rq1 = c1_valid && !c1_write;
    gw0 = 0; gw1 = 0; gr0 = 0; gr1 = 0;
    if (!RST) begin
      if (wq0 && wq1) begin gw0 = (m_wr_prio == 0); gw1 = !gw0; end
      else begin gw0 = wq0; gw1 = wq1; end
      if (rq0 && rq1) begin gr0 = (m_rd_prio == 0); gr1 = !gr0; end
      else begin gr0 = rq0; gr1 = rq1; end
`ifndef ALTMEM_ARB_FWD_EN
      ra = gr0 ? c0_addr : c1_addr;
      wa = gw0 ? c0_addr : c1_addr;
      if ((gr0 || gr1) && (gw0 || gw1) && ra == wa) begin gr0 = 0; gr1 = 0; end
`endif
    end
    chk("c0_ready", DW'(c0_ready), DW'(gw0 || gr0));
    chk("c1_ready", DW'(c1_ready), DW'(gw1 || gr1));
    chk("mem_wen",  DW'(mem_wen),  DW'(gw0 || gw1));
    chk("mem_ren",  DW'(mem_ren),  DW'(gr0 || gr1));
    if (RST) begin
      m_wr_prio = 0; m_rd_prio = 0;
    end else begin
      if (wq0 && wq1) m_wr_prio = gw0;
      if (rq0 && rq1 && (gr0 || gr1)) m_rd_prio = gr0;
      // a read sees the write accepted in the same cycle
      if (gw0) model_mem[c0_addr] = c0_wdata;
      if (gw1) model_mem[c1_addr] = c1_wdata;
      if (gr0) begin exp_q0.push_back(model_mem[c0_addr]); due_q0.push_back(cyc + 1); end
      if (gr1) begin exp_q1.push_back(model_mem[c1_addr]); due_q1.push_back(cyc + 1); end
    end
  end

  // monitor client 0
  bit fin0 = 0;
  always @(negedge CLK) begin
    logic [DW-1:0] d;
    if (due_q0.size() > 0 && due_q0[0] == cyc) begin
      d = exp_q0.pop_front();
      void'(due_q0.pop_front());
      if (RST) chk("c0_rsp_valid_in_reset", DW'(c0_rsp_valid), '0);
      else begin
        chk("c0_rsp_valid", DW'(c0_rsp_valid), DW'(1));
        if (c0_rsp_valid) chk("c0_rsp_data", c0_rsp_data, d);
      end
    end else chk("c0_rsp_valid_idle", DW'(c0_rsp_valid), '0);
    if (done && !fin0) begin
      fin0 = 1;
      chk("c0_pending_left", DW'(exp_q0.size()), '0);
    end
  end

  // monitor client 1
  bit fin1 = 0;
  always @(negedge CLK) begin
    logic [DW-1:0] d;
    if (due_q1.size() > 0 && due_q1[0] == cyc) begin
      d = exp_q1.pop_front();
      void'(due_q1.pop_front());
      if (RST) chk("c1_rsp_valid_in_reset", DW'(c1_rsp_valid), '0);
      else begin
        chk("c1_rsp_valid", DW'(c1_rsp_valid), DW'(1));
        if (c1_rsp_valid) chk("c1_rsp_data", c1_rsp_data, d);
      end
    end else chk("c1_rsp_valid_idle", DW'(c1_rsp_valid), '0);
    if (done && !fin1) begin
      fin1 = 1;
      chk("c1_pending_left", DW'(exp_q1.size()), '0);
    end
  end

  // driver tasks (entered and left just after a rising edge)
  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // present one request per client and hold each until accepted
  task automatic req(input bit v0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input bit v1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bit ok0, ok1;
    int budget;
    c0_valid = v0; c0_write = w0; c0_addr = a0; c0_wdata = d0;
    c1_valid = v1; c1_write = w1; c1_addr = a1; c1_wdata = d1;
    budget = 0;
    while ((c0_valid || c1_valid) && budget < 20) begin
      @(negedge CLK);
      ok0 = c0_valid && c0_ready;
      ok1 = c1_valid && c1_ready;
      @(posedge CLK); #1;
      if (ok0) c0_valid = 0;
      if (ok1) c1_valid = 0;
      budget++;
    end
    chk("req_c0_accepted", DW'(c0_valid), '0);
    chk("req_c1_accepted", DW'(c1_valid), '0);
    c0_valid = 0; c1_valid = 0;
  endtask

  // new request for client k; mode 1 = contested writes, 2 = reads, else random
  task automatic gen(input int k, input int mode);
    bit v, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    case (mode)
      1: begin v = 1; w = 1; a = (k == 0) ? AW'(1) : AW'(2); end
      2: begin v = 1; w = 0; a = AW'($urandom_range(0, 3)); end
      default: begin
        v = ($urandom_range(0, 9) < 7);
        w = ($urandom_range(0, 1) == 1);
        a = AW'($urandom_range(0, 7));
      end
    endcase
    if (k == 0) begin c0_valid = v; c0_write = w; c0_addr = a; c0_wdata = d; end
    else        begin c1_valid = v; c1_write = w; c1_addr = a; c1_wdata = d; end
  endtask

  // independent request streams: a client issues anew right after acceptance
  task automatic stream(input int ncyc, input int mode);
    bit hold0, hold1;
    hold0 = 0; hold1 = 0;
    for (int i = 0; i < ncyc + 20; i++) begin
      if (!hold0) begin if (i < ncyc) gen(0, mode); else c0_valid = 0; end
      if (!hold1) begin if (i < ncyc) gen(1, mode); else c1_valid = 0; end
      if (i >= ncyc && !c0_valid && !c1_valid) break;
      @(negedge CLK);
      hold0 = c0_valid && !c0_ready;
      hold1 = c1_valid && !c1_ready;
      @(posedge CLK); #1;
    end
    chk("stream_drained", DW'(c0_valid || c1_valid), '0);
    c0_valid = 0; c1_valid = 0;
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin
    for (int i = 0; i < (1 << AW); i++) begin ram[i] = '0; model_mem[i] = '0; end
    RST = 1;
    idle(3);
    RST = 0;

    // solo read after a write
    req(1, 1, 9'h010, 64'h1122334455667788, 0, 0, '0, '0);
    req(1, 0, 9'h010, '0, 0, 0, '0, '0);
    idle(2);

    // contested writes, then read both addresses back
    stream(4, 1);
    req(1, 0, 9'h001, '0, 1, 0, 9'h002, '0);
    idle(1);

    // split ports in one cycle
    req(1, 0, 9'h020, '0, 1, 1, 9'h030, 64'hDEAD_BEEF_0000_0030);
    idle(1);

    // collision: c0 reads 0x040 (old 0x55) while c1 writes 0xAA there
    req(1, 1, 9'h040, 64'h55, 0, 0, '0, '0);
    req(1, 0, 9'h040, '0, 1, 1, 9'h040, 64'hAA);
    idle(1);

    // read in the cycle right after a same-address write
    req(1, 1, 9'h050, 64'h77, 0, 0, '0, '0);
    req(1, 0, 9'h050, '0, 0, 0, '0, '0);
    idle(1);

    // mid-operation reset: skew priorities, accept a read, reset on its response cycle
    stream(5, 2);
    stream(3, 1);
    c0_valid = 1; c0_write = 0; c0_addr = 9'h050;
    @(negedge CLK);
    @(posedge CLK); #1;
    c0_valid = 0;
    RST = 1;
    idle(2);
    RST = 0;
    // priorities must be back at client 0
    req(1, 1, 9'h060, 64'h600, 1, 1, 9'h061, 64'h601);
    req(1, 0, 9'h061, '0, 1, 0, 9'h060, '0);
    idle(1);

    // randomized traffic over a small address window
    stream(600, 0);
    idle(3);
    done = 1;
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
